// File: rtl/dmg_pkg.sv
// Shared definitions for the OAM DMA block: FSM states, fixed addresses and
// the echo-RAM source fold used when forming DMA read addresses.
package dmg_pkg;

    // DMA engine states; each one lasts exactly one clock.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RD_PH = 2'd2,
        WR_PH = 2'd3
    } dma_state_t;

    // CPU-visible DMA source register.
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    // Index of the final OAM byte (160 bytes, 0x00..0x9F).
    localparam logic [7:0] OAM_LAST = 8'h9F;

    // Sources at or above ECHO_BASE alias work RAM; ECHO_MASK folds them down.
    localparam logic [7:0] ECHO_BASE = 8'hE0;
    localparam logic [7:0] ECHO_MASK = 8'hDF;

    // Value the CPU sees on reads it is locked out of during a transfer.
    localparam logic [7:0] LOCKOUT_DATA = 8'hFF;

    // Map a source page to the page actually read from the bus.
    function automatic logic [7:0] echo_fold(input logic [7:0] src);
        return (src >= ECHO_BASE) ? (src & ECHO_MASK) : src;
    endfunction

endpackage

// File: rtl/oam_dma_addr_gen.sv
// Byte index counter and source-address formation for OAM DMA.
// The index restarts at zero whenever a new transfer is accepted and steps
// once per completed OAM write until the last byte has been written.
module oam_dma_addr_gen
    import dmg_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_advance,
    input  logic [7:0]  i_src_hi,
    output logic [7:0]  o_idx,
    output logic        o_last,
    output logic [15:0] o_rd_addr
);

    logic [7:0] r_idx;
    logic [7:0] w_eff_src;
    logic       w_last;

    // Index register: clear on reset or on a newly accepted transfer,
    // otherwise step after each OAM write that is not the final one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx <= 8'h00;
        end else if (i_clear) begin
            r_idx <= 8'h00;
        end else if (i_advance && !w_last) begin
            r_idx <= r_idx + 8'd1;
        end
    end

    // Source page with the echo region folded onto work RAM, and the
    // final-byte flag the FSM uses to leave the transfer.
    always_comb begin
        w_eff_src = echo_fold(i_src_hi);
        w_last    = (r_idx == OAM_LAST);
    end

    assign o_idx     = r_idx;
    assign o_last    = w_last;
    assign o_rd_addr = {w_eff_src, r_idx};

endmodule

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine plus CPU/DMA bus arbiter.
// A CPU write to FF46 latches a source page and (re)starts a 160-byte copy
// into OAM: one START cycle, then alternating bus-read / OAM-write cycles.
// While the copy runs the CPU is fenced off the external bus; otherwise CPU
// traffic passes straight through. FF46 itself never reaches the bus.
// Bus strobes are plain level signals: MREQ/RD/WR high for a cycle means
// one access at A in that cycle; D_in is taken at the end of a read cycle.
module oam_dma_arbiter
    import dmg_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mreq,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    input  logic [7:0]  D_in,
    output logic        MREQ,
    output logic        RD,
    output logic        WR,
    output logic [7:0]  oam_a,
    output logic [7:0]  oam_d,
    output logic        oam_we,
    output logic        dma_active,
    output dma_state_t  o_dbg_state
);

    dma_state_t  r_state;
    dma_state_t  w_state_nxt;
    logic [7:0]  r_src_hi;
    logic [7:0]  r_data;

    logic        w_is_dma_reg;
    logic        w_dma_reg_wr;
    logic        w_dma_reg_rd;
    logic        w_active;
    logic        w_rd_phase;
    logic        w_wr_phase;

    logic [7:0]  w_idx;
    logic        w_last;
    logic [15:0] w_rd_addr;

    // Decode of CPU accesses to the DMA source register.
    always_comb begin
        w_is_dma_reg = (cpu_a == DMA_REG_ADDR);
        w_dma_reg_wr = cpu_mreq & cpu_wr & w_is_dma_reg;
        w_dma_reg_rd = cpu_mreq & cpu_rd & w_is_dma_reg;
    end

    oam_dma_addr_gen u_addr_gen (
        .i_clk     (CLK),
        .i_reset   (RESET),
        .i_clear   (w_dma_reg_wr),
        .i_advance (w_wr_phase),
        .i_src_hi  (r_src_hi),
        .o_idx     (w_idx),
        .o_last    (w_last),
        .o_rd_addr (w_rd_addr)
    );

    // State register; reset wins over a simultaneous FF46 write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and phase flags. An FF46 write forces START from any
    // state, including the final write cycle, so a restart is never lost.
    always_comb begin
        w_state_nxt = r_state;
        w_active    = 1'b0;
        w_rd_phase  = 1'b0;
        w_wr_phase  = 1'b0;
        case (r_state)
            IDLE: begin
                w_state_nxt = IDLE;
            end
            START: begin
                w_active    = 1'b1;
                w_state_nxt = RD_PH;
            end
            RD_PH: begin
                w_active    = 1'b1;
                w_rd_phase  = 1'b1;
                w_state_nxt = WR_PH;
            end
            WR_PH: begin
                w_active    = 1'b1;
                w_wr_phase  = 1'b1;
                w_state_nxt = w_last ? IDLE : RD_PH;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_dma_reg_wr) begin
            w_state_nxt = START;
        end
    end

    // DMA source page, written only by the CPU through FF46.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_src_hi <= 8'h00;
        end else if (w_dma_reg_wr) begin
            r_src_hi <= cpu_dout;
        end
    end

    // Byte fetched in the read phase, held for the following OAM write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_data <= 8'h00;
        end else if (w_rd_phase) begin
            r_data <= D_in;
        end
    end

    // Bus and OAM mux: DMA owns the bus while active, otherwise the CPU
    // passes through except for FF46, which is answered locally.
    always_comb begin
        A       = cpu_a;
        D_out   = cpu_dout;
        MREQ    = 1'b0;
        RD      = 1'b0;
        WR      = 1'b0;
        cpu_din = D_in;
        oam_a   = 8'h00;
        oam_d   = 8'h00;
        oam_we  = 1'b0;
        if (w_active) begin
            A       = w_rd_addr;
            D_out   = 8'h00;
            MREQ    = w_rd_phase;
            RD      = w_rd_phase;
            cpu_din = LOCKOUT_DATA;
        end else if (!w_is_dma_reg) begin
            MREQ = cpu_mreq;
            RD   = cpu_rd;
            WR   = cpu_wr;
        end
        if (w_wr_phase) begin
            oam_a  = w_idx;
            oam_d  = r_data;
            oam_we = 1'b1;
        end
        if (w_dma_reg_rd) begin
            cpu_din = r_src_hi;
        end
    end

    assign dma_active  = w_active;
    assign o_dbg_state = r_state;

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have ports: CLK  in  1  single core clock; all state changes on rising edge.
REQ-002 SHALL have ports: RESET  in  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 SHALL have ports: cpu_a  in  16  CPU address; cpu_dout  in  8  CPU write data; cpu_mreq, cpu_rd, cpu_wr  in  1 each  CPU request strobes.
REQ-004 SHALL have ports: cpu_din  out  8  read data returned to CPU.
REQ-005 SHALL have ports: A  out  16  external bus address; D_out  out  8  bus write data; D_in  in  8  bus read data; MREQ, RD, WR  out  1 each  bus strobes.
REQ-006 SHALL have ports: oam_a  out  8  OAM byte index; oam_d  out  8  OAM write data; oam_we  out  1  OAM write strobe.
REQ-007 SHALL have ports: dma_active  out  1  high while DMA owns the bus.

Function
REQ-008 SHALL decode a DMA-register write as cpu_mreq & cpu_wr & cpu_a==16'hFF46, sampled at a CLK edge; this write latches src_hi = cpu_dout and is never forwarded to the bus.
REQ-009 SHALL return src_hi on cpu_din for a CPU read of FF46, in any state, with no bus cycle.
REQ-010 SHALL use the FSM IDLE -> START -> RD_PH -> WR_PH -> (RD_PH | IDLE); each state lasts exactly 1 cycle.
REQ-011 SHALL enter START on the edge that accepts an FF46 write, from any state, including mid-transfer (restart).
REQ-012 SHALL clear idx to 0 on entry to START.
REQ-013 SHALL, in RD_PH, drive A = {eff_src, idx}, MREQ=1, RD=1, WR=0, and register D_in at the end of the cycle.
REQ-014 SHALL compute eff_src = src_hi & 8'hDF when src_hi >= 8'hE0 (echo mirror); otherwise eff_src = src_hi.
REQ-015 SHALL, in WR_PH, drive oam_a=idx, oam_d=registered byte, oam_we=1, and keep MREQ, RD and WR at 0.
REQ-016 SHALL, at the end of WR_PH, go to IDLE if idx==8'h9F; otherwise increment idx and return to RD_PH.
REQ-017 SHALL make a transfer last 1+320=321 cycles, with dma_active high in START, RD_PH and WR_PH only.
REQ-018 SHALL, while dma_active=0, pass all non-FF46 CPU traffic through combinationally (A=cpu_a, D_out=cpu_dout, MREQ/RD/WR=cpu strobes, cpu_din=D_in).
REQ-019 SHALL, while dma_active=1, return 8'hFF on cpu_din for non-FF46 CPU reads, silently drop non-FF46 CPU writes, and keep CPU strobes off the bus; HRAM decode is upstream of this block.
REQ-020 SHALL give FF46 precedence when the CPU writes FF46 in the same cycle as the last WR_PH: that OAM write completes, and the FSM then enters START, not IDLE.
REQ-021 SHALL keep oam_we=0 in every state except WR_PH.

Reset
REQ-022 SHALL, on RESET=1 at an edge, set state=IDLE, idx=0, src_hi=8'h00 and the registered data byte=8'h00.
REQ-023 SHALL, the cycle after RESET, drive dma_active=0, oam_we=0, oam_a=0 and oam_d=0; bus outputs follow CPU passthrough.
REQ-024 SHALL make a reset mid-transfer abort the transfer with no further OAM writes; reset takes precedence over a simultaneous FF46 write.

Structure
REQ-025 SHALL place in shared package dmg_pkg: the state enum (IDLE, START, RD_PH, WR_PH), DMA_REG_ADDR=16'hFF46, OAM_LAST=8'h9F and ECHO_MASK=8'hDF.
REQ-026 SHALL isolate the idx counter and the eff_src/address formation in one sub-module, oam_dma_addr_gen; the FSM and bus mux stay in the top level.

Verification
REQ-027 SHALL cover basic transfer: CPU writes 8'hC0 to FF46, bus model returns D_in = low address byte -> 160 oam_we pulses with oam_a=oam_d=0..9F, A sweeps C000..C09F, dma_active high exactly 321 cycles.
REQ-028 SHALL cover echo source: write 8'hE3 -> first RD_PH drives A=16'hC300.
REQ-029 SHALL cover CPU lockout: CPU reads 16'h8000 during DMA -> cpu_din=8'hFF and MREQ stays low in WR_PH; CPU write to 16'hC000 during DMA -> WR never asserted.
REQ-030 SHALL cover restart: write 8'hC0, then write 8'hD0 when idx=8'h40 -> START, idx=0, next A=16'hD000, then 160 further writes.
REQ-031 SHALL cover reset mid-op: RESET asserted for one cycle at idx=8'h10 -> following cycle dma_active=0, oam_we=0, and no further OAM writes.
REQ-032 SHALL cover DMA-register readback: write 8'h55 to FF46, read FF46 during and after DMA -> cpu_din=8'h55 both times.
